// File: rtl/led_matrix_driver_pkg.sv
// Shared types and helpers for the 3x3 mole-lamp matrix driver.
// Addresses use the keypad key-code layout {row[1:0], col[1:0]}.
package led_matrix_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;
    localparam int NUM_LEDS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        OP_SET     = 2'b00,
        OP_CLR     = 2'b01,
        OP_TGL     = 2'b10,
        OP_CLR_ALL = 2'b11
    } cmd_op_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [3:0] led_idx(input logic [1:0] r, input logic [1:0] c);
        return ({2'b00, r} * 4'd3) + {2'b00, c};
    endfunction

    // A field value of 3 has no lamp behind it.
    function automatic logic addr_valid(input logic [3:0] a);
        return (a[3:2] != 2'd3) && (a[1:0] != 2'd3);
    endfunction

endpackage

// File: rtl/led_matrix_driver_if.sv
// Lamp command bus between game logic (master) and the matrix driver (slave).
interface led_matrix_driver_if;
    import led_matrix_pkg::*;

    logic        cmd_valid;
    cmd_op_t     cmd_op;
    logic [3:0]  cmd_addr;
    logic        cmd_error;

    modport master (output cmd_valid, output cmd_op, output cmd_addr, input cmd_error);
    modport slave  (input cmd_valid, input cmd_op, input cmd_addr, output cmd_error);

endinterface

// File: rtl/led_matrix_driver_scan_timer.sv
// Loadable up-counter with a terminal-count flag; used for both the
// column prescaler and the inter-column blanking counter.
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/led_matrix_driver.sv
// 3x3 multiplexed LED matrix driver: command-written frame, per-frame shadow
// snapshot, and column scan with a blanking gap between columns.
module led_matrix_driver
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 41666,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    led_matrix_driver_if.slave        cmd,
    output logic [NUM_COLS-1:0]       column,
    output logic [NUM_ROWS-1:0]       row,
    output logic                      frame_sync
);

    logic [NUM_LEDS-1:0] frame, frame_nxt;
    logic [NUM_LEDS-1:0] shadow, shadow_nxt;
    logic                err_nxt;

    scan_state_t         state, state_nxt;
    logic [1:0]          col, col_nxt;
    logic                load_shadow;

    logic                blank_inc, blank_clr, blank_tc;
    logic                presc_inc, presc_clr, presc_tc;

    logic [NUM_COLS-1:0] column_nxt;
    logic [NUM_ROWS-1:0] row_nxt;

    // Counters only advance inside their own state; holding them at zero
    // elsewhere gives the clear-on-entry behaviour for free.
    always_comb begin
        blank_inc = enable && (state == ST_BLANK) && !blank_tc;
        blank_clr = !blank_inc;
        presc_inc = enable && (state == ST_DRIVE) && !presc_tc;
        presc_clr = !presc_inc;
    end

    scan_timer #(.W(16)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .load     (presc_clr),
        .load_val ('0),
        .inc      (presc_inc),
        .term     (16'(SCAN_DIV - 1)),
        .tc       (presc_tc)
    );

    scan_timer #(.W(8)) u_blank_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (blank_clr),
        .load_val ('0),
        .inc      (blank_inc),
        .term     (8'(BLANK_CYCLES - 1)),
        .tc       (blank_tc)
    );

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        if (!enable) begin
            state_nxt = ST_BLANK;
            col_nxt   = 2'd0;
        end else begin
            unique case (state)
                ST_BLANK: begin
                    if (blank_tc) state_nxt = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (presc_tc) begin
                        state_nxt = ST_BLANK;
                        col_nxt   = (col == 2'd2) ? 2'd0 : col + 2'd1;
                    end
                end
                default: state_nxt = ST_BLANK;
            endcase
        end
    end

    // The snapshot takes the current frame register, so a command landing
    // on the same edge only shows up in the following frame.
    always_comb begin
        load_shadow = (state == ST_BLANK) && (state_nxt == ST_DRIVE) && (col_nxt == 2'd0);
        shadow_nxt  = load_shadow ? frame : shadow;
    end

    always_comb begin
        frame_nxt = frame;
        err_nxt   = 1'b0;
        if (cmd.cmd_valid) begin
            if (cmd.cmd_op == OP_CLR_ALL) begin
                frame_nxt = '0;
            end else if (!addr_valid(cmd.cmd_addr)) begin
                err_nxt = 1'b1;
            end else begin
                unique case (cmd.cmd_op)
                    OP_SET:  frame_nxt[led_idx(cmd.cmd_addr[3:2], cmd.cmd_addr[1:0])] = 1'b1;
                    OP_CLR:  frame_nxt[led_idx(cmd.cmd_addr[3:2], cmd.cmd_addr[1:0])] = 1'b0;
                    OP_TGL:  frame_nxt[led_idx(cmd.cmd_addr[3:2], cmd.cmd_addr[1:0])] =
                                 !frame[led_idx(cmd.cmd_addr[3:2], cmd.cmd_addr[1:0])];
                    default: frame_nxt = frame;
                endcase
            end
        end
    end

    // Outputs are decoded from next-state values so column and row
    // register together on the same edge as the FSM.
    always_comb begin
        column_nxt = '1;
        row_nxt    = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            column_nxt[c] = !((state_nxt == ST_DRIVE) && (col_nxt == 2'(c)));
        end
        if (state_nxt == ST_DRIVE) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                row_nxt[r] = shadow_nxt[led_idx(2'(r), col_nxt)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_BLANK;
            col           <= 2'd0;
            frame         <= '0;
            shadow        <= '0;
            column        <= '1;
            row           <= '0;
            frame_sync    <= 1'b0;
            cmd.cmd_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            col           <= col_nxt;
            frame         <= frame_nxt;
            shadow        <= shadow_nxt;
            column        <= column_nxt;
            row           <= row_nxt;
            frame_sync    <= load_shadow;
            cmd.cmd_error <= err_nxt;
        end
    end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Directed bench for led_matrix_driver with SCAN_DIV=4, BLANK_CYCLES=2
// (column period 6 clocks, frame period 18 clocks).
module tb_led_matrix_driver;
    import led_matrix_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] column;
    logic [2:0] row;
    logic       frame_sync;

    int checks = 0;
    int errors = 0;

    led_matrix_driver_if cif ();

    led_matrix_driver #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cmd        (cif),
        .column     (column),
        .row        (row),
        .frame_sync (frame_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic issue(input cmd_op_t op, input logic [3:0] addr);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_addr  = addr;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_sync(input string tag, input logic [2:0] exp_row_before);
        logic found;
        logic bad;
        found = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (frame_sync) found = 1'b1;
            else begin
                if (column == 3'b110 && row !== exp_row_before) bad = 1'b1;
                tick();
            end
        end
        chk({tag, "_sync_seen"}, 9'(found), 9'd1);
        chk({tag, "_pre_sync_c0"}, 9'(bad), 9'd0);
    endtask

    // Starts on a frame_sync cycle and ends on the next one.
    task automatic scan_frame(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                              input logic [2:0] e2);
        logic [2:0] r0, r1, r2;
        logic       bad;
        r0 = 'x; r1 = 'x; r2 = 'x;
        bad = 1'b0;
        for (int i = 0; i < 18; i++) begin
            case (column)
                3'b110:  r0 = row;
                3'b101:  r1 = row;
                3'b011:  r2 = row;
                3'b111:  if (row !== 3'b000) bad = 1'b1;
                default: bad = 1'b1;
            endcase
            tick();
        end
        chk({tag, "_col0"}, 9'(r0), 9'(e0));
        chk({tag, "_col1"}, 9'(r1), 9'(e1));
        chk({tag, "_col2"}, 9'(r2), 9'(e2));
        chk({tag, "_blank"}, 9'(bad), 9'd0);
    endtask

    logic [2:0] exp_col [9];
    logic       exp_fs  [9];

    initial begin
        exp_col = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b101};
        exp_fs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset         = 1'b1;
        enable        = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_SET;
        cif.cmd_addr  = 4'b0000;
        tick();
        tick();
        chk("rst_column", 9'(column), 9'h7);
        chk("rst_row", 9'(row), 9'h0);
        chk("rst_sync", 9'(frame_sync), 9'h0);
        chk("rst_err", 9'(cif.cmd_error), 9'h0);
        chk("rst_frame", dut.frame, 9'h0);

        // Start-up timing after reset release
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("start_col_%0d", i), 9'(column), 9'(exp_col[i]));
            chk($sformatf("start_fs_%0d", i), 9'(frame_sync), 9'(exp_fs[i]));
            chk($sformatf("start_row_%0d", i), 9'(row), 9'h0);
            if (i < 8) tick();
        end

        // Set row 1 col 2
        issue(OP_SET, 4'b0110);
        chk("set12_frame", dut.frame, 9'h020);
        chk("set12_err", 9'(cif.cmd_error), 9'h0);
        wait_sync("set12", 3'b000);
        scan_frame("set12_scan", 3'b000, 3'b000, 3'b010);

        // Invalid column field
        issue(OP_SET, 4'b0011);
        chk("bad_err_hi", 9'(cif.cmd_error), 9'h1);
        chk("bad_frame", dut.frame, 9'h020);
        tick();
        chk("bad_err_lo", 9'(cif.cmd_error), 9'h0);
        wait_sync("bad", 3'b000);
        scan_frame("bad_scan", 3'b000, 3'b000, 3'b010);

        // Set bit 0 mid-frame during column 1
        for (int i = 0; i < 7; i++) tick();
        chk("mid_at_col1", 9'(column), 9'h5);
        issue(OP_SET, 4'b0000);
        chk("mid_frame", dut.frame, 9'h021);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_col2_column", 9'(column), 9'h3);
        chk("mid_col2_row_stale", 9'(row), 9'h2);
        wait_sync("mid", 3'b000);
        chk("mid_sync_row", 9'(row), 9'h1);
        scan_frame("mid_scan", 3'b001, 3'b000, 3'b010);

        // Toggle twice, then clear-all
        issue(OP_TGL, 4'b0000);
        chk("tgl1_frame", dut.frame, 9'h020);
        issue(OP_TGL, 4'b0000);
        chk("tgl2_frame", dut.frame, 9'h021);
        issue(OP_CLR_ALL, 4'b1111);
        chk("clrall_frame", dut.frame, 9'h000);
        chk("clrall_err", 9'(cif.cmd_error), 9'h0);
        wait_sync("clrall", 3'b001);
        scan_frame("clrall_scan", 3'b000, 3'b000, 3'b000);

        // Command on the same edge the shadow is loaded
        for (int i = 0; i < 17; i++) tick();
        chk("race_pre_column", 9'(column), 9'h7);
        issue(OP_SET, 4'b0000);
        chk("race_sync", 9'(frame_sync), 9'h1);
        chk("race_frame", dut.frame, 9'h001);
        scan_frame("race_scan_old", 3'b000, 3'b000, 3'b000);
        scan_frame("race_scan_new", 3'b001, 3'b000, 3'b000);

        // Drop enable while column 1 is lit
        for (int i = 0; i < 6; i++) tick();
        chk("dis_pre_column", 9'(column), 9'h5);
        enable = 1'b0;
        tick();
        chk("dis_column", 9'(column), 9'h7);
        chk("dis_row", 9'(row), 9'h0);
        issue(OP_SET, 4'b1000);
        chk("dis_cmd_frame", dut.frame, 9'h041);
        chk("dis_hold_column", 9'(column), 9'h7);

        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("re_col_%0d", i), 9'(column), 9'(exp_col[i]));
            chk($sformatf("re_fs_%0d", i), 9'(frame_sync), 9'(exp_fs[i]));
            chk($sformatf("re_row_%0d", i), 9'(row),
                (exp_col[i] == 3'b110) ? 9'h5 : 9'h0);
            if (i < 8) tick();
        end

        // Asynchronous reset mid-drive
        reset = 1'b1;
        #1;
        chk("arst_column", 9'(column), 9'h7);
        chk("arst_row", 9'(row), 9'h0);
        chk("arst_frame", dut.frame, 9'h000);
        tick();
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
